if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and drives the instruction ROM word address; the ROM is combinational and indexes words by address bits [7:2].
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls, control-flow redirects (jump/branch), and pipeline flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit request: hold PC and IF/ID contents.
- redirect  input  1  decode/execute resolved a taken jump or branch.
- redirect_pc  input  32  target byte address for redirect.
- flush  input  1  invalidate IF/ID, e.g. on exception or external squash.
- imem_addr  output  32  byte address to the instruction ROM; equals the PC register.
- imem_inst  input  32  instruction word returned combinationally for imem_addr.
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_pc4  output  32  id_pc + 4, used for jump-target concatenation and link.
- id_inst  output  32  instruction held in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_cnt  output  32  count of instructions accepted into IF/ID with valid=1.

Behaviour:
Reset (rst_n=0, asynchronous, effective immediately and regardless of clk):
- pc = RESET_PC, id_pc = 0, id_pc4 = 0, id_inst = NOP_INST, id_valid = 0, fetch_cnt = 0.
- Reset asserted mid-operation discards all in-flight state; the first fetch after deassertion is from RESET_PC.

PC update per rising edge, in priority order:
1. redirect=1: pc <= {redirect_pc[31:2], 2'b00}. Redirect overrides stall. Bits [1:0] are always forced to 0.
2. else stall=1: pc holds.
3. else: pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).

IF/ID update per rising edge, in priority order:
1. flush=1 or redirect=1: id_inst <= NOP_INST, id_valid <= 0. id_pc and id_pc4 hold. The wrong-path instruction currently at imem_addr is discarded.
2. else stall=1: all IF/ID fields hold.
3. else: id_pc <= pc, id_pc4 <= pc + 4, id_inst <= imem_inst, id_valid <= 1.

Other rules:
- imem_addr = pc, combinational from the register. The total IF-to-ID latency is exactly one cycle.
- fetch_cnt increments by 1 on each edge where case 3 of the IF/ID update applies. It wraps at 2^32.
- stall and redirect together: the PC takes the redirect target and IF/ID receives a bubble. The decode stage must not see a stale repeat.
- flush alone, without redirect, does not affect the PC; the PC advances or holds per stall.
- Back-to-back redirects: each redirect wins on its own edge. Only the last target is fetched.
- No combinational path from any input to any output other than imem_inst -> (registered) id_inst. Outputs are all registered except imem_addr, which is also a register output.

Test Plan:
1. Reset, then free-run 4 cycles with ROM word0=0x00000000, word1=0x14000801, word2=0x14002422 -> after reset imem_addr=0, id_valid=0. Then id_pc is 0, 4, 8 on successive edges with id_inst 0x00000000, 0x14000801, 0x14002422, id_valid=1, and fetch_cnt reaches 3.
2. Pulse redirect=1 with redirect_pc=0x18 while imem_addr=0x14 -> the next edge gives imem_addr=0x18 and id_valid=0, id_inst=0. The following edge gives id_pc=0x18, id_pc4=0x1C, id_valid=1. The instruction at 0x14 never appears in IF/ID.
3. Hold stall=1 for 2 cycles at pc=0x0C -> imem_addr stays 0x0C and IF/ID is unchanged for 2 edges. fetch_cnt does not change. After release, id_pc=0x0C appears next.
4. Assert stall=1 and redirect=1 together with redirect_pc=0x23 -> imem_addr=0x20 (low bits cleared) and id_valid=0. A separate flush-only pulse gives id_valid=0 while the PC still advances by 4.
5. Preload pc to 0xFFFF_FFFC via redirect, then free-run -> imem_addr wraps to 0x0000_0000, and id_pc4 for the 0xFFFF_FFFC instruction is 0x0000_0000.
6. Drop rst_n asynchronously between clock edges mid-run -> imem_addr=0, id_valid=0, and fetch_cnt=0 immediately, without waiting for a clock edge. On release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and loads the IF/ID pipeline register for decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        squash;
    logic        accept;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // A redirect also squashes IF/ID: the word at the old PC is wrong-path.
    assign squash = flush | redirect;
    assign accept = ~squash & ~stall;

    // Next-PC selection: redirect beats stall, otherwise sequential advance.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID pipeline register: bubble on squash, hold on stall, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc    <= '0;
            id_pc4   <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (squash) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_pc    <= pc;
            id_pc4   <= pc_plus4;
            id_inst  <= imem_inst;
            id_valid <= 1'b1;
        end
    end

    // Count instructions accepted into IF/ID as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
        end else if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule
